// File: rtl/clock_pkg.sv
// Shared clock definitions: field width, default moduli and the
// time-keeper state enum. Also used by the alarm block.
package clock_pkg;

    localparam int FIELD_W    = 8;
    localparam int DEF_SECOND = 60;
    localparam int DEF_MINUTE = 60;
    localparam int DEF_HOUR   = 24;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

endpackage

// File: rtl/mod_counter.sv
// Single time field counting 0..MOD-1.
// Ports:
//   clk, rst_n  - clock, async active-low reset (value -> 0)
//   clear       - synchronous load of zero (highest priority)
//   inc, dec    - one-cycle step requests; inc has priority, both wrap
//   value       - current field value
//   wrap        - high while value is MOD-1 (next increment wraps)
module mod_counter
    import clock_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               inc,
    input  logic               dec,
    output logic [FIELD_W-1:0] value,
    output logic               wrap
);

    localparam logic [FIELD_W-1:0] MAX = FIELD_W'(MOD - 1);

    if (MOD < 1 || MOD > 255) begin : g_bad_mod
        $error("mod_counter: MOD=%0d does not fit an 8-bit field", MOD);
    end

    assign wrap = (value == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == MAX) ? '0 : value + 8'd1;
        end else if (dec) begin
            value <= (value == '0) ? MAX : value - 8'd1;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Free-running HH:MM:SS wall clock with a SET mode for manual editing.
// Ports:
//   clk, rst_n       - system clock, async active-low reset
//   run_en           - 1 lets the prescaler and time advance in RUN
//   set_mode         - 1 selects SET, 0 selects RUN
//   signal_increase  - per-field step-up buttons (bit0 sec, bit1 min, bit2 hour)
//   signal_decrease  - per-field step-down buttons, same encoding
//   cur_second/minute/hour - current time, binary
//   tick_1hz         - one-cycle pulse per RUN-mode second advance
//   day_rollover     - one-cycle pulse on the 23:59:59 -> 00:00:00 advance
//
// state  | meaning
// ST_RUN | prescaler counts, fields advance on terminal count
// ST_SET | prescaler held at 0, fields stepped by button rising edges
module time_keeper
    import clock_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int SECOND  = DEF_SECOND,
    parameter int MINUTE  = DEF_MINUTE,
    parameter int HOUR    = DEF_HOUR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_en,
    input  logic               set_mode,
    input  logic [2:0]         signal_increase,
    input  logic [2:0]         signal_decrease,
    output logic [FIELD_W-1:0] cur_second,
    output logic [FIELD_W-1:0] cur_minute,
    output logic [FIELD_W-1:0] cur_hour,
    output logic               tick_1hz,
    output logic               day_rollover
);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("time_keeper: CLK_DIV=%0d must be >= 2", CLK_DIV);
    end

    localparam int            PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    state_t        state, state_nxt;
    logic [PW-1:0] presc;
    logic [2:0]    inc_q, dec_q;
    logic [2:0]    rise_inc, rise_dec;
    logic [2:0]    step_inc, step_dec;
    logic          adv;
    logic          sec_wrap, min_wrap, hour_wrap;

    assign rise_inc = signal_increase & ~inc_q;
    assign rise_dec = signal_decrease & ~dec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_RUN;
        adv       = 1'b0;
        step_inc  = '0;
        step_dec  = '0;
        if (set_mode) begin
            state_nxt = ST_SET;
        end
        case (state)
            ST_RUN: adv = run_en && (presc == PRESC_LAST);
            ST_SET: begin
                step_inc = rise_inc;
                // Increase wins when both buttons rise on the same field.
                step_dec = rise_dec & ~rise_inc;
            end
            default: ;
        endcase
    end

    // Edge history tracks the buttons in every state so a level held
    // across RUN does not re-step on return to SET.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            inc_q        <= '0;
            dec_q        <= '0;
            tick_1hz     <= 1'b0;
            day_rollover <= 1'b0;
        end else begin
            inc_q        <= signal_increase;
            dec_q        <= signal_decrease;
            tick_1hz     <= adv;
            day_rollover <= adv && sec_wrap && min_wrap && hour_wrap;
            if (state == ST_SET) begin
                presc <= '0;
            end else if (run_en) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            end
        end
    end

    // Carries only come from the prescaler advance; SET edits never carry.
    mod_counter #(.MOD(SECOND)) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (adv | step_inc[0]),
        .dec   (step_dec[0]),
        .value (cur_second),
        .wrap  (sec_wrap)
    );

    mod_counter #(.MOD(MINUTE)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   ((adv & sec_wrap) | step_inc[1]),
        .dec   (step_dec[1]),
        .value (cur_minute),
        .wrap  (min_wrap)
    );

    mod_counter #(.MOD(HOUR)) u_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   ((adv & sec_wrap & min_wrap) | step_inc[2]),
        .dec   (step_dec[2]),
        .value (cur_hour),
        .wrap  (hour_wrap)
    );

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Free-running wall-clock generator for the multi-mode clock; the source of the cur_second/cur_minute/cur_hour buses that the alarm block compares against.
- Divides the system clock down to a 1 Hz tick and advances an HH:MM:SS counter chain with carries.
- Offers a SET mode in which the user steps each field up or down using the same 3-bit increase/decrease button encoding as the alarm setter.

Parameters:
- CLK_DIV, 50_000_000, system clock cycles per second; must be >= 2.
- SECOND, 60, seconds field modulus; field counts 0..SECOND-1.
- MINUTE, 60, minutes field modulus.
- HOUR, 24, hours field modulus.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run_en  in  1  1 = time advances; 0 = prescaler and time frozen.
- set_mode  in  1  1 = SET state, 0 = RUN state.
- signal_increase  in  3  bit0 sec, bit1 min, bit2 hour; level, stepped on rising edge.
- signal_decrease  in  3  same encoding, decrement.
- cur_second  out  8  current seconds, binary.
- cur_minute  out  8  current minutes, binary.
- cur_hour  out  8  current hours, binary.
- tick_1hz  out  1  one-cycle pulse on every RUN-mode second advance.
- day_rollover  out  1  one-cycle pulse on the advance from (HOUR-1):(MINUTE-1):(SECOND-1) to 00:00:00.

Behaviour:
- Reset (rst_n=0, async): cur_* = 0, tick_1hz = 0, day_rollover = 0, prescaler = 0, state = RUN, edge-detect history = 0.
- FSM states: RUN and SET. Next state is SET when set_mode=1, otherwise RUN; evaluated every cycle.
- Prescaler (RUN with run_en=1): counts 0..CLK_DIV-1.
  - On the edge where the prescaler equals CLK_DIV-1: it wraps to 0, the seconds field advances, and tick_1hz=1 for exactly that following cycle.
  - Consequence: the first tick after reset occurs CLK_DIV cycles after rst_n deasserts.
- run_en=0 in RUN: prescaler and fields hold; no pulses.
- Carry chain:
  - Seconds wrap SECOND-1 -> 0 and carry into minutes.
  - Minutes wrap MINUTE-1 -> 0 and carry into hours.
  - Hours wrap HOUR-1 -> 0. The hour wrap asserts day_rollover in the same cycle as tick_1hz.
  - All carries land on the same edge; there is no ripple latency.
- SET state:
  - Prescaler is held at 0 and no ticks are produced.
  - Each field reacts independently to a rising edge (0 in the previous cycle, 1 now) of its own increase/decrease bit.
  - The step is visible on the next cycle. A held level produces exactly one step.
  - Increment wraps max -> 0; decrement wraps 0 -> max.
  - Edits never carry into the neighbouring field.
- Simultaneous rising edges of increase and decrease on the same field: increase wins and decrease is ignored. Different fields may step in the same cycle.
- Increase/decrease edges in RUN state are ignored. The edge history still updates, so a button held across SET -> RUN -> SET does not re-step.
- SET -> RUN: prescaler restarts from 0, so the next tick comes a full second (CLK_DIV cycles) later.
- Reset mid-second or mid-edit: returns immediately to 00:00:00 RUN with no pulse emitted.
- Width rule: fields are 8-bit unsigned. Moduli greater than 255 are illegal and are flagged by a simulation-time parameter check.

Decomposition:
- Shared package clock_pkg holds the field width constant (8), the default moduli 60/60/24, and the state enum {ST_RUN, ST_SET}. The alarm block reuses the width and moduli from this package.
- One sub-module, mod_counter: single field with modulus parameter, inc/dec/load-zero inputs, and a wrap output. Instantiated three times; the hour instance's wrap drives day_rollover.

Test Plan (CLK_DIV=4, default moduli):
- Reset release, run_en=1, set_mode=0 -> tick_1hz first high 4 cycles after release; cur_second=1; thereafter ticks every 4 cycles.
- Preload 23:59:58 via SET steps, then RUN -> two ticks later cur = 00:00:00; day_rollover and tick_1hz pulse together for one cycle.
- SET mode, signal_increase=3'b001 held 10 cycles -> cur_second +1 exactly once; release and re-press -> +1 again; no ticks throughout.
- SET mode at 00:00:00, pulse signal_decrease=3'b110 -> cur_minute=59, cur_hour=23, cur_second=0, no borrow.
- SET mode, increase=3'b001 and decrease=3'b001 rise together at cur_second=10 -> cur_second=11.
- RUN at 12:34:56 with prescaler mid-count, assert rst_n=0 asynchronously -> all outputs 0 immediately, with no pulse; run_en=0 afterwards -> time stays frozen.
